seg7_scan_driver: RTL and testbench

- Downstream consumer of the 8-bit seven-segment PIO register output.
- Converts the PIO value to three display digits: 0-255 decimal via sequential double-dabble, or 2-digit hex.
- Time-multiplexes the digits onto a 3-digit common-anode display with a programmable refresh rate and a dead-time cycle between digits.
- Optional leading-zero blanking; a busy flag indicates a conversion in flight.

---
 rtl/seg7_scan_driver.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
//
// Purpose:
//   Takes the 8-bit value written to the seven-segment PIO register and shows
//   it on a 3-digit common-anode display. In decimal mode the value (0-255) is
//   converted to BCD by a sequential double-dabble (one shift per clock). In
//   hex mode the two nibbles are shown directly and the hundreds digit is
//   blank. The digits are time-multiplexed, with one dead cycle between digit
//   slots so that two anodes are never on together.
//
// Parameters:
//   CLK_DIV      clk cycles per digit slot (>= 2); a digit is lit CLK_DIV-1 of them
//
// Ports:
//   clk          system clock
//   reset_n      asynchronous, active-low reset
//   data_in      value from the PIO out_port
//   dec_mode     1 = decimal display, 0 = hex display
//   blank_zeros  1 = suppress leading zeros
//   seg_n        segments {g,f,e,d,c,b,a}, active-low (registered)
//   dp_n         decimal point, active-low; lit only on digit0 in hex mode
//   dig_n        digit enables, active-low; bit0 = least significant digit
//   busy         high while a conversion is in flight
// -----------------------------------------------------------------------------
module seg7_scan_driver #(
    parameter int CLK_DIV = 50000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] data_in,
    input  logic       dec_mode,
    input  logic       blank_zeros,
    output logic [6:0] seg_n,
    output logic       dp_n,
    output logic [2:0] dig_n,
    output logic       busy
);

    localparam int              PW      = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0]   PRE_MAX = PW'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LOAD  = 2'd2
    } state_t;

    // Double-dabble correction: a BCD nibble of 5 or more gets +3 before the shift.
    function automatic logic [3:0] dd_adjust(input logic [3:0] nib);
        dd_adjust = (nib >= 4'd5) ? (nib + 4'd3) : nib;
    endfunction

    // Active-high glyph for a hex digit.
    function automatic logic [6:0] glyph(input logic [3:0] nib);
        case (nib)
            4'h0:    glyph = 7'h3F;
            4'h1:    glyph = 7'h06;
            4'h2:    glyph = 7'h5B;
            4'h3:    glyph = 7'h4F;
            4'h4:    glyph = 7'h66;
            4'h5:    glyph = 7'h6D;
            4'h6:    glyph = 7'h7D;
            4'h7:    glyph = 7'h07;
            4'h8:    glyph = 7'h7F;
            4'h9:    glyph = 7'h6F;
            4'hA:    glyph = 7'h77;
            4'hB:    glyph = 7'h7C;
            4'hC:    glyph = 7'h39;
            4'hD:    glyph = 7'h5E;
            4'hE:    glyph = 7'h79;
            4'hF:    glyph = 7'h71;
            default: glyph = 7'h00;
        endcase
    endfunction

    // Input stage
    logic [8:0]    r_in_q;       // {dec_mode, data_in}
    logic          r_in_vld;     // r_in_q holds a real sample (false only right after reset)
    logic          r_blank;

    // Conversion
    state_t        r_state;
    state_t        w_state_nxt;
    logic [8:0]    r_conv_src;
    logic [8:0]    w_conv_src_nxt;
    logic          r_src_valid;
    logic          w_src_valid_nxt;
    logic [19:0]   r_shreg;      // [19:8] = three result nibbles, [7:0] = binary being shifted out
    logic [19:0]   w_shreg_nxt;
    logic [2:0]    r_cnt;
    logic [2:0]    w_cnt_nxt;
    logic          w_load_disp;
    logic          w_start;
    logic          w_restart;
    logic [19:0]   w_start_shreg;
    state_t        w_start_state;
    logic [19:0]   w_adj;
    logic          r_busy;

    // Display registers
    logic [3:0]    r_dig2;
    logic [3:0]    r_dig1;
    logic [3:0]    r_dig0;
    logic          r_hex_mode;

    // Scan
    logic [PW-1:0] r_pre;
    logic [1:0]    r_idx;
    logic [6:0]    r_seg_n;
    logic          r_dp_n;
    logic [2:0]    r_dig_n;
    logic [3:0]    w_cur_nib;
    logic          w_cur_blank;
    logic [2:0]    w_cur_dig_n;
    logic          w_cur_dp_n;

    // Register the PIO value, mode and blanking control every cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_in_q   <= 9'd0;
            r_in_vld <= 1'b0;
            r_blank  <= 1'b0;
        end else begin
            r_in_q   <= {dec_mode, data_in};
            r_in_vld <= 1'b1;
            r_blank  <= blank_zeros;
        end
    end

    // Conversion next-state and datapath logic.
    always_comb begin
        w_state_nxt     = r_state;
        w_conv_src_nxt  = r_conv_src;
        w_src_valid_nxt = r_src_valid;
        w_shreg_nxt     = r_shreg;
        w_cnt_nxt       = r_cnt;
        w_load_disp     = 1'b0;

        w_start   = r_in_vld && (!r_src_valid || (r_in_q != r_conv_src));
        w_restart = r_in_q != r_conv_src;
        // Hex needs no conversion: park the nibbles where LOAD picks up BCD.
        if (r_in_q[8]) begin
            w_start_shreg = {12'd0, r_in_q[7:0]};
            w_start_state = ST_SHIFT;
        end else begin
            w_start_shreg = {4'd0, r_in_q[7:4], r_in_q[3:0], 8'd0};
            w_start_state = ST_LOAD;
        end
        w_adj = {dd_adjust(r_shreg[19:16]), dd_adjust(r_shreg[15:12]),
                 dd_adjust(r_shreg[11:8]), r_shreg[7:0]};

        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_conv_src_nxt  = r_in_q;
                    w_src_valid_nxt = 1'b1;
                    w_shreg_nxt     = w_start_shreg;
                    w_cnt_nxt       = 3'd0;
                    w_state_nxt     = w_start_state;
                end else begin
                    w_state_nxt     = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                // A new input abandons the partial result; nothing reaches the display.
                if (w_restart) begin
                    w_conv_src_nxt = r_in_q;
                    w_shreg_nxt    = w_start_shreg;
                    w_cnt_nxt      = 3'd0;
                    w_state_nxt    = w_start_state;
                end else begin
                    w_shreg_nxt = {w_adj[18:0], 1'b0};
                    w_cnt_nxt   = r_cnt + 3'd1;
                    if (r_cnt == 3'd7) begin
                        w_state_nxt = ST_LOAD;
                    end else begin
                        w_state_nxt = ST_SHIFT;
                    end
                end
            end
            ST_LOAD: begin
                w_load_disp = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Conversion state, datapath and display registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_conv_src  <= 9'd0;
            r_src_valid <= 1'b0;
            r_shreg     <= 20'd0;
            r_cnt       <= 3'd0;
            r_busy      <= 1'b0;
            r_dig2      <= 4'd0;
            r_dig1      <= 4'd0;
            r_dig0      <= 4'd0;
            r_hex_mode  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_conv_src  <= w_conv_src_nxt;
            r_src_valid <= w_src_valid_nxt;
            r_shreg     <= w_shreg_nxt;
            r_cnt       <= w_cnt_nxt;
            r_busy      <= (w_state_nxt != ST_IDLE);
            if (w_load_disp) begin
                r_dig2     <= r_shreg[19:16];
                r_dig1     <= r_shreg[15:12];
                r_dig0     <= r_shreg[11:8];
                r_hex_mode <= ~r_conv_src[8];
            end else begin
                r_dig2     <= r_dig2;
                r_dig1     <= r_dig1;
                r_dig0     <= r_dig0;
                r_hex_mode <= r_hex_mode;
            end
        end
    end

    // Glyph, blanking and enable for the digit selected by the scan index.
    always_comb begin
        w_cur_nib   = 4'd0;
        w_cur_blank = 1'b0;
        w_cur_dig_n = 3'b111;
        w_cur_dp_n  = 1'b1;
        case (r_idx)
            2'd0: begin
                w_cur_nib   = r_dig0;
                w_cur_blank = 1'b0;
                w_cur_dig_n = 3'b110;
                w_cur_dp_n  = ~r_hex_mode;
            end
            2'd1: begin
                w_cur_nib   = r_dig1;
                w_cur_blank = r_blank && (r_dig1 == 4'd0) && (r_dig2 == 4'd0);
                w_cur_dig_n = 3'b101;
            end
            2'd2: begin
                w_cur_nib   = r_dig2;
                w_cur_blank = r_hex_mode || (r_blank && (r_dig2 == 4'd0));
                w_cur_dig_n = 3'b011;
            end
            default: begin
                w_cur_nib   = 4'd0;
                w_cur_blank = 1'b1;
                w_cur_dig_n = 3'b111;
            end
        endcase
    end

    // Scan prescaler, digit index and registered display outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pre   <= '0;
            r_idx   <= 2'd0;
            r_seg_n <= 7'h7F;
            r_dp_n  <= 1'b1;
            r_dig_n <= 3'b111;
        end else begin
            if (r_pre == PRE_MAX) begin
                // Dead cycle: everything off before moving to the next digit.
                r_pre   <= '0;
                r_idx   <= (r_idx == 2'd2) ? 2'd0 : (r_idx + 2'd1);
                r_seg_n <= 7'h7F;
                r_dp_n  <= 1'b1;
                r_dig_n <= 3'b111;
            end else if (r_pre == '0) begin
                r_pre   <= r_pre + 1'b1;
                r_idx   <= r_idx;
                r_seg_n <= w_cur_blank ? 7'h7F : ~glyph(w_cur_nib);
                r_dp_n  <= w_cur_dp_n;
                r_dig_n <= w_cur_dig_n;
            end else begin
                r_pre   <= r_pre + 1'b1;
                r_idx   <= r_idx;
                r_seg_n <= r_seg_n;
                r_dp_n  <= r_dp_n;
                r_dig_n <= r_dig_n;
            end
        end
    end

    assign seg_n = r_seg_n;
    assign dp_n  = r_dp_n;
    assign dig_n = r_dig_n;
    assign busy  = r_busy;

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

    localparam int CLK_DIV = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] data_in;
    logic       dec_mode;
    logic       blank_zeros;
    logic [6:0] seg_n;
    logic       dp_n;
    logic [2:0] dig_n;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    seg7_scan_driver #(.CLK_DIV(CLK_DIV)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .data_in     (data_in),
        .dec_mode    (dec_mode),
        .blank_zeros (blank_zeros),
        .seg_n       (seg_n),
        .dp_n        (dp_n),
        .dig_n       (dig_n),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       dec;
        logic       blk;
        int         lat;   // edge on which busy falls; 0 = no conversion expected
        logic [6:0] e2;
        logic [6:0] e1;
        logic [6:0] e0;
        logic       dp0;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Busy over edges 1..lat after inputs change (inputs set just before edge 1).
    task automatic check_busy(input string name, input int lat);
        int last;
        last = (lat == 0) ? 3 : lat;
        for (int k = 1; k <= last; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("%s busy@%0d", name, k), {31'd0, busy},
                {31'd0, (lat != 0) && (k >= 2) && (k < lat)});
        end
    endtask

    // Observe one full scan and compare each digit's glyph.
    task automatic check_display(input string name, input logic [6:0] e2, input logic [6:0] e1,
                                 input logic [6:0] e0, input logic dp0);
        logic [6:0] s0, s1, s2;
        logic       d0, ok;
        logic [2:0] seen;
        s0 = 7'h7F; s1 = 7'h7F; s2 = 7'h7F; d0 = 1'b1; ok = 1'b1; seen = 3'b000;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 3 * CLK_DIV; i++) begin
            @(negedge clk);
            case (dig_n)
                3'b110: begin s0 = seg_n; d0 = dp_n; seen[0] = 1'b1; end
                3'b101: begin s1 = seg_n; seen[1] = 1'b1; if (dp_n !== 1'b1) ok = 1'b0; end
                3'b011: begin s2 = seg_n; seen[2] = 1'b1; if (dp_n !== 1'b1) ok = 1'b0; end
                3'b111: begin if (seg_n !== 7'h7F || dp_n !== 1'b1) ok = 1'b0; end
                default: ok = 1'b0;
            endcase
        end
        chk({name, " seg0"}, {25'd0, s0}, {25'd0, e0});
        chk({name, " seg1"}, {25'd0, s1}, {25'd0, e1});
        chk({name, " seg2"}, {25'd0, s2}, {25'd0, e2});
        chk({name, " dp0"}, {31'd0, d0}, {31'd0, dp0});
        chk({name, " scan_ok"}, {28'd0, ok, seen}, {28'd0, 1'b1, 3'b111});
    endtask

    initial begin
        int         fall;
        logic       bad_glyph;
        logic [2:0] exp_dig;

        vecs[0] = '{8'hFF, 1'b1, 1'b1, 11, 7'h24, 7'h12, 7'h12, 1'b1};
        vecs[1] = '{8'hAB, 1'b0, 1'b1, 3,  7'h7F, 7'h08, 7'h03, 1'b0};
        vecs[2] = '{8'h07, 1'b1, 1'b0, 11, 7'h40, 7'h40, 7'h78, 1'b1};
        vecs[3] = '{8'h07, 1'b1, 1'b1, 0,  7'h7F, 7'h7F, 7'h78, 1'b1};
        vecs[4] = '{8'h00, 1'b0, 1'b0, 3,  7'h7F, 7'h40, 7'h40, 1'b0};
        vecs[5] = '{8'h64, 1'b1, 1'b1, 11, 7'h79, 7'h40, 7'h40, 1'b1};
        vecs[6] = '{8'h0A, 1'b1, 1'b1, 11, 7'h7F, 7'h79, 7'h40, 1'b1};
        vecs[7] = '{8'hF0, 1'b0, 1'b0, 3,  7'h7F, 7'h0E, 7'h40, 1'b0};

        // Reset state
        reset_n     = 1'b0;
        data_in     = 8'h00;
        dec_mode    = 1'b1;
        blank_zeros = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst seg_n", {25'd0, seg_n}, {25'd0, 7'h7F});
        chk("rst dig_n", {29'd0, dig_n}, {29'd0, 3'b111});
        chk("rst dp_n", {31'd0, dp_n}, 32'd1);
        chk("rst busy", {31'd0, busy}, 32'd0);

        // Release: busy edges 2-10 and the exact scan pattern from index 0
        @(negedge clk);
        reset_n = 1'b1;
        for (int e = 1; e <= 24; e++) begin
            @(posedge clk);
            #1;
            chk($sformatf("post-rst busy@%0d", e), {31'd0, busy}, {31'd0, (e >= 2) && (e <= 10)});
            case (((e - 1) / CLK_DIV) % 3)
                0:       exp_dig = 3'b110;
                1:       exp_dig = 3'b101;
                default: exp_dig = 3'b011;
            endcase
            if (((e - 1) % CLK_DIV) == CLK_DIV - 1) exp_dig = 3'b111;
            chk($sformatf("scan dig_n@%0d", e), {29'd0, dig_n}, {29'd0, exp_dig});
        end
        check_display("zero", 7'h7F, 7'h7F, 7'h40, 1'b1);

        // Table-driven vectors
        for (int v = 0; v < 8; v++) begin
            @(negedge clk);
            data_in     = vecs[v].d;
            dec_mode    = vecs[v].dec;
            blank_zeros = vecs[v].blk;
            check_busy($sformatf("vec%0d", v), vecs[v].lat);
            check_display($sformatf("vec%0d", v), vecs[v].e2, vecs[v].e1, vecs[v].e0, vecs[v].dp0);
        end

        // Restart: 123 abandoned for 42 mid-conversion
        @(negedge clk);
        data_in     = 8'h7B;
        dec_mode    = 1'b1;
        blank_zeros = 1'b1;
        fall        = 0;
        bad_glyph   = 1'b0;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            #1;
            if (e >= 2 && fall == 0 && busy !== 1'b1) fall = e;
            if ((dig_n == 3'b110 && seg_n == 7'h30) || (dig_n == 3'b101 && seg_n == 7'h24) ||
                (dig_n == 3'b011 && seg_n == 7'h79)) bad_glyph = 1'b1;
            if (e == 5) begin
                @(negedge clk);
                data_in = 8'h2A;
            end
        end
        chk("restart busy_fall_edge", fall, 32'd16);
        chk("restart no_intermediate", {31'd0, bad_glyph}, 32'd0);
        check_display("restart", 7'h7F, 7'h19, 7'h24, 1'b1);

        // Reset mid-conversion and mid-scan
        @(negedge clk);
        data_in     = 8'h55;
        blank_zeros = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst seg_n", {25'd0, seg_n}, {25'd0, 7'h7F});
        chk("midrst dig_n", {29'd0, dig_n}, {29'd0, 3'b111});
        chk("midrst dp_n", {31'd0, dp_n}, 32'd1);
        chk("midrst busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        check_busy("after midrst", 11);
        check_display("after midrst", 7'h40, 7'h00, 7'h12, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
